// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the LC-3b branch resolve unit: queue entry, pointer, FSM states
// and a saturating counter helper used when BRU_STATS_EN is defined.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int unsigned BRU_DEPTH = 8;

    typedef logic [2:0] lc3b_bru_ptr;

    typedef struct packed {
        lc3b_word pc;
        logic     pred;
        lc3b_word target;
    } lc3b_bru_entry;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } lc3b_bru_state;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_queue.sv
// bru_queue: 8-entry in-order circular queue of in-flight predicted branches.
// Clear empties the queue by snapping head onto tail and wins over push/pop.
module bru_queue
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [15:0] push_pc,
    input  logic        push_pred,
    input  logic [15:0] push_target,
    output logic [15:0] head_pc,
    output logic        head_pred,
    output logic [15:0] head_target,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
);

    lc3b_bru_entry entries_r [BRU_DEPTH];
    lc3b_bru_ptr   head_r;
    lc3b_bru_ptr   tail_r;
    logic [3:0]    count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    lc3b_bru_entry head_entry_s;

    // Qualify push/pop against occupancy so the pointers can never overrun.
    always_comb begin
        full_s       = (count_r == 4'd8);
        empty_s      = (count_r == 4'd0);
        push_ok_s    = push && !clear && !full_s;
        pop_ok_s     = pop && !clear && !empty_s;
        head_entry_s = entries_r[head_r];
    end

    // Head/tail pointers and occupancy; 3-bit pointers wrap 7 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= 3'd0;
            tail_r  <= 3'd0;
            count_r <= 4'd0;
        end else if (clear) begin
            head_r  <= tail_r;
            count_r <= 4'd0;
        end else begin
            if (push_ok_s) begin
                tail_r <= tail_r + 3'd1;
            end
            if (pop_ok_s) begin
                head_r <= head_r + 3'd1;
            end
            count_r <= count_r + {3'd0, push_ok_s} - {3'd0, pop_ok_s};
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BRU_DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            entries_r[tail_r] <= '{pc: push_pc, pred: push_pred, target: push_target};
        end
    end

    assign head_pc     = head_entry_s.pc;
    assign head_pred   = head_entry_s.pred;
    assign head_target = head_entry_s.target;
    assign count       = count_r;
    assign full        = full_s;
    assign empty       = empty_s;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: tracks predicted branches, trains the predictor and raises
// a flush on mispredictions. Optional counters are enabled by macro BRU_STATS_EN.
module branch_resolve_unit
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc_valid,
    input  logic [15:0] alloc_pc,
    input  logic        alloc_pred,
    input  logic [15:0] alloc_target,
    output logic        alloc_ready,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    output logic        ld_pred_unit,
    output logic [15:0] old_pc,
    output logic        taken_in,
    output logic        flush,
    output logic [15:0] flush_pc,
    output logic [3:0]  inflight
`ifdef BRU_STATS_EN
    ,
    output logic [15:0] br_count,
    output logic [15:0] mispred_count
`endif
);

    lc3b_bru_state state_r;
    lc3b_bru_state state_nxt_s;

    logic [15:0] head_pc_s;
    logic        head_pred_s;
    logic [15:0] head_target_s;
    logic [3:0]  count_s;
    logic        full_s;
    logic        empty_s;

    logic        alloc_ready_s;
    logic        res_accept_s;
    logic        mispred_s;
    logic        push_s;
    logic        pop_s;

    logic        ld_pred_unit_r;
    logic [15:0] old_pc_r;
    logic        taken_in_r;
    logic        flush_r;
    logic [15:0] flush_pc_r;

    bru_queue u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .pop         (pop_s),
        .clear       (mispred_s),
        .push_pc     (alloc_pc),
        .push_pred   (alloc_pred),
        .push_target (alloc_target),
        .head_pc     (head_pc_s),
        .head_pred   (head_pred_s),
        .head_target (head_target_s),
        .count       (count_s),
        .full        (full_s),
        .empty       (empty_s)
    );

    // Handshake and misprediction compare; a target mismatch only matters when both say taken.
    always_comb begin
        alloc_ready_s = (state_r == RUN) && !full_s;
        res_accept_s  = res_valid && (state_r == RUN) && !empty_s;
        mispred_s     = 1'b0;
        if (res_accept_s) begin
            if (head_pred_s != res_taken) begin
                mispred_s = 1'b1;
            end else if (res_taken && (head_target_s != res_target)) begin
                mispred_s = 1'b1;
            end else begin
                mispred_s = 1'b0;
            end
        end else begin
            mispred_s = 1'b0;
        end
        push_s = alloc_valid && alloc_ready_s && !mispred_s;
        pop_s  = res_accept_s && !mispred_s;
    end

    // Next-state logic: a misprediction costs one FLUSH and one RECOVER cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (mispred_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH:   state_nxt_s = RECOVER;
            RECOVER: state_nxt_s = RUN;
            default: state_nxt_s = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Predictor training write and redirect; flush_r is high exactly in the FLUSH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pred_unit_r <= 1'b0;
            old_pc_r       <= 16'h0000;
            taken_in_r     <= 1'b0;
            flush_r        <= 1'b0;
            flush_pc_r     <= 16'h0000;
        end else begin
            ld_pred_unit_r <= res_accept_s;
            flush_r        <= mispred_s;
            if (res_accept_s) begin
                old_pc_r   <= head_pc_s;
                taken_in_r <= res_taken;
            end
            if (mispred_s) begin
                flush_pc_r <= res_taken ? res_target : (head_pc_s + 16'd2);
            end
        end
    end

    assign alloc_ready  = alloc_ready_s;
    assign ld_pred_unit = ld_pred_unit_r;
    assign old_pc       = old_pc_r;
    assign taken_in     = taken_in_r;
    assign flush        = flush_r;
    assign flush_pc     = flush_pc_r;
    assign inflight     = count_s;

`ifdef BRU_STATS_EN
    logic [15:0] br_count_r;
    logic [15:0] mispred_count_r;

    // Saturating resolution and misprediction counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_r      <= 16'h0000;
            mispred_count_r <= 16'h0000;
        end else begin
            if (res_accept_s) begin
                br_count_r <= sat_inc16(br_count_r);
            end
            if (mispred_s) begin
                mispred_count_r <= sat_inc16(mispred_count_r);
            end
        end
    end

    assign br_count      = br_count_r;
    assign mispred_count = mispred_count_r;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of expected training writes.
// Define BRU_STATS_EN for both bench and RTL to also check the counters.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic [15:0] alloc_pc;
    logic        alloc_pred;
    logic [15:0] alloc_target;
    logic        alloc_ready;
    logic        res_valid;
    logic        res_taken;
    logic [15:0] res_target;
    logic        ld_pred_unit;
    logic [15:0] old_pc;
    logic        taken_in;
    logic        flush;
    logic [15:0] flush_pc;
    logic [3:0]  inflight;
`ifdef BRU_STATS_EN
    logic [15:0] br_count;
    logic [15:0] mispred_count;
`endif

    int passes = 0;
    int total  = 0;
    logic [16:0] sb [$];
    logic [15:0] pcq [$];
    int br_exp  = 0;
    int mis_exp = 0;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_pc     (alloc_pc),
        .alloc_pred   (alloc_pred),
        .alloc_target (alloc_target),
        .alloc_ready  (alloc_ready),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_target   (res_target),
        .ld_pred_unit (ld_pred_unit),
        .old_pc       (old_pc),
        .taken_in     (taken_in),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .inflight     (inflight)
`ifdef BRU_STATS_EN
        ,
        .br_count     (br_count),
        .mispred_count(mispred_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input logic av, input logic [15:0] apc, input logic apred,
                          input logic [15:0] atgt, input logic rv, input logic rt,
                          input logic [15:0] rtgt);
        alloc_valid  = av;
        alloc_pc     = apc;
        alloc_pred   = apred;
        alloc_target = atgt;
        res_valid    = rv;
        res_taken    = rt;
        res_target   = rtgt;
    endtask

    task automatic idle();
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    // Expect a resolution of the model head to be accepted at the next edge.
    task automatic expect_res(input logic rt, input logic mis);
        sb.push_back({pcq[0], rt});
        br_exp++;
        if (mis) begin
            mis_exp++;
            pcq.delete();
        end else begin
            void'(pcq.pop_front());
        end
    endtask

    // Advance one clock; every cycle the training write is compared with the scoreboard.
    task automatic tick();
        logic [16:0] e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ld_pred_unit", {31'd0, ld_pred_unit}, 32'd1);
            chk("old_pc", {16'd0, old_pc}, {16'd0, e[16:1]});
            chk("taken_in", {31'd0, taken_in}, {31'd0, e[0]});
        end else begin
            chk("ld_pred_unit_idle", {31'd0, ld_pred_unit}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld", {31'd0, ld_pred_unit}, 32'd0);
        chk("rst_old_pc", {16'd0, old_pc}, 32'd0);
        chk("rst_taken_in", {31'd0, taken_in}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_flush_pc", {16'd0, flush_pc}, 32'd0);
        chk("rst_inflight", {28'd0, inflight}, 32'd0);
        chk("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);

        // Correct not-taken branch; allocation right after reset release.
        rst_n = 1'b1;
        set_in(1'b1, 16'h3000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        pcq.push_back(16'h3000);
        tick();
        chk("t1_inflight1", {28'd0, inflight}, 32'd1);
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        expect_res(1'b0, 1'b0);
        tick();
        chk("t1_flush", {31'd0, flush}, 32'd0);
        chk("t1_inflight0", {28'd0, inflight}, 32'd0);
        idle();
        tick();

        // Fill to eight, drop a ninth, then overlap allocate with resolve.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 16'h3100 + 16'(2 * i), 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            pcq.push_back(16'h3100 + 16'(2 * i));
            tick();
        end
        chk("t2_full_inflight", {28'd0, inflight}, 32'd8);
        chk("t2_full_ready", {31'd0, alloc_ready}, 32'd0);
        set_in(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("t2_drop_inflight", {28'd0, inflight}, 32'd8);
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        expect_res(1'b0, 1'b0);
        tick();
        chk("t2_inflight7", {28'd0, inflight}, 32'd7);
        set_in(1'b1, 16'h4002, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        expect_res(1'b0, 1'b0);
        pcq.push_back(16'h4002);
        tick();
        chk("t2_overlap_inflight", {28'd0, inflight}, 32'd7);
        set_in(1'b1, 16'h4004, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        pcq.push_back(16'h4004);
        tick();
        chk("t2_refill_inflight", {28'd0, inflight}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
            expect_res(1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        chk("t2_drained", {28'd0, inflight}, 32'd0);

        // Taken with wrong target; a same-cycle allocation must be dropped.
        set_in(1'b1, 16'h3010, 1'b1, 16'h3040, 1'b0, 1'b0, 16'h0000);
        pcq.push_back(16'h3010);
        tick();
        set_in(1'b1, 16'h3020, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h3050);
        expect_res(1'b1, 1'b1);
        tick();
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_flush_pc", {16'd0, flush_pc}, 32'h3050);
        chk("t3_inflight", {28'd0, inflight}, 32'd0);
        chk("t3_ready_flush", {31'd0, alloc_ready}, 32'd0);
        idle();
        tick();
        chk("t3_flush_drop", {31'd0, flush}, 32'd0);
        chk("t3_ready_recover", {31'd0, alloc_ready}, 32'd0);
        chk("t3_flush_pc_hold", {16'd0, flush_pc}, 32'h3050);
        tick();
        chk("t3_ready_run", {31'd0, alloc_ready}, 32'd1);

        // Predicted taken, resolved not taken at 0xFFFE: fall-through wraps to 0.
        set_in(1'b1, 16'hFFFE, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
        pcq.push_back(16'hFFFE);
        tick();
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        expect_res(1'b0, 1'b1);
        tick();
        chk("t4_flush", {31'd0, flush}, 32'd1);
        chk("t4_flush_pc", {16'd0, flush_pc}, 32'h0000);
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222);
        tick();
        chk("t4_recover_flush", {31'd0, flush}, 32'd0);
        idle();
        tick();

        // Resolution with an empty queue is ignored.
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5555);
        tick();
        chk("t5_flush", {31'd0, flush}, 32'd0);
        chk("t5_inflight", {28'd0, inflight}, 32'd0);
        chk("t5_ready", {31'd0, alloc_ready}, 32'd1);

        // Taken with matching target is correct; not-taken prediction resolved taken redirects.
        set_in(1'b1, 16'h5000, 1'b1, 16'h5100, 1'b0, 1'b0, 16'h0000);
        pcq.push_back(16'h5000);
        tick();
        set_in(1'b1, 16'h5002, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5100);
        expect_res(1'b1, 1'b0);
        pcq.push_back(16'h5002);
        tick();
        chk("t6_no_flush", {31'd0, flush}, 32'd0);
        chk("t6_inflight", {28'd0, inflight}, 32'd1);
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h6000);
        expect_res(1'b1, 1'b1);
        tick();
        chk("t6_flush", {31'd0, flush}, 32'd1);
        chk("t6_flush_pc", {16'd0, flush_pc}, 32'h6000);
`ifdef BRU_STATS_EN
        chk("stats_br", {16'd0, br_count}, 32'(br_exp));
        chk("stats_mis", {16'd0, mispred_count}, 32'(mis_exp));
`endif

        // Reset asserted during FLUSH clears everything at once.
        idle();
        rst_n = 1'b0;
        #1;
        chk("t7_flush", {31'd0, flush}, 32'd0);
        chk("t7_inflight", {28'd0, inflight}, 32'd0);
        chk("t7_ready", {31'd0, alloc_ready}, 32'd1);
        chk("t7_flush_pc", {16'd0, flush_pc}, 32'd0);
`ifdef BRU_STATS_EN
        chk("t7_br_count", {16'd0, br_count}, 32'd0);
        chk("t7_mis_count", {16'd0, mispred_count}, 32'd0);
`endif
        pcq.delete();
        #2;
        rst_n = 1'b1;
        set_in(1'b1, 16'h7000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        pcq.push_back(16'h7000);
        tick();
        chk("t7_first_alloc", {28'd0, inflight}, 32'd1);
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        expect_res(1'b0, 1'b0);
        tick();
        chk("t7_drained", {28'd0, inflight}, 32'd0);
        idle();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
